// File: rtl/multdiv_issue.sv
// Execute-stage initiator for the multdiv unit: latches a MULT/DIV, pulses start, stalls until ready/timeout/flush.
// Issue at cycle 0 -> md_start at 1 -> ready first accepted at k>=3 -> wb_valid at k+1; upstream stalled from START to the ready cycle.
`timescale 1ns/1ps

module multdiv_issue #(
  parameter int WIDTH   = 32,
  parameter int RW      = 5,
  parameter int TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic             issue_is_div,
  input  logic [WIDTH-1:0] issue_a,
  input  logic [WIDTH-1:0] issue_b,
  input  logic [RW-1:0]    issue_rd,
  input  logic             flush,
  output logic             md_start,
  output logic             md_is_div,
  output logic [WIDTH-1:0] md_a,
  output logic [WIDTH-1:0] md_b,
  input  logic             md_ready,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  output logic             stall,
  output logic             wb_valid,
  output logic [RW-1:0]    wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_exception,
  output logic             hang_error
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [RW-1:0] rd_q;
  logic          take_issue;

  assign take_issue = issue_valid && !flush;

  // A flush in START must suppress the pulse in the same cycle, so the start is gated combinationally.
  assign md_start = (state == START) && !flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      rd_q         <= '0;
      md_is_div    <= 1'b0;
      md_a         <= '0;
      md_b         <= '0;
      stall        <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
      hang_error   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE, WB: begin
          if (take_issue) begin
            state     <= START;
            stall     <= 1'b1;
            md_is_div <= issue_is_div;
            md_a      <= issue_a;
            md_b      <= issue_b;
            rd_q      <= issue_rd;
          end else begin
            state <= IDLE;
            stall <= 1'b0;
          end
        end
        START: begin
          wait_cnt <= '0;
          if (flush) begin
            state <= IDLE;
            stall <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
            stall <= 1'b0;
          end else if (wait_cnt != '0 && md_ready) begin
            // wait_cnt==0 is the first WAIT cycle, where ready still reflects the previous op.
            state        <= WB;
            stall        <= 1'b0;
            wb_valid     <= 1'b1;
            wb_rd        <= rd_q;
            wb_data      <= md_result;
            wb_exception <= md_exception;
          end else if (wait_cnt == CNT_MAX) begin
            state        <= WB;
            stall        <= 1'b0;
            wb_valid     <= 1'b1;
            wb_rd        <= rd_q;
            wb_data      <= '0;
            wb_exception <= 1'b1;
            hang_error   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_issue.sv
// Bench for multdiv_issue: a cycle-indexed model of one operation drives a fake multdiv unit and predicts every output.
`timescale 1ns/1ps

module tb_multdiv_issue;
  localparam int WIDTH   = 32;
  localparam int RW      = 5;
  localparam int TIMEOUT = 40;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             issue_valid, issue_is_div, flush;
  logic [WIDTH-1:0] issue_a, issue_b;
  logic [RW-1:0]    issue_rd;
  logic             md_start, md_is_div, md_ready, md_exception;
  logic [WIDTH-1:0] md_a, md_b, md_result;
  logic             stall, wb_valid, wb_exception, hang_error;
  logic [RW-1:0]    wb_rd;
  logic [WIDTH-1:0] wb_data;

  int vectors     = 0;
  int miscompares = 0;

  logic             hang_seen;
  logic [RW-1:0]    last_rd;
  logic [WIDTH-1:0] last_data;
  logic             last_exc;

  always #5 clock = ~clock;

  multdiv_issue #(.WIDTH(WIDTH), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd), .flush(flush),
    .md_start(md_start), .md_is_div(md_is_div), .md_a(md_a), .md_b(md_b),
    .md_ready(md_ready), .md_result(md_result), .md_exception(md_exception),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception), .hang_error(hang_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_hold();
    check("wb_rd", 64'(wb_rd), 64'(last_rd));
    check("wb_data", 64'(wb_data), 64'(last_data));
    check("wb_exception", 64'(wb_exception), 64'(last_exc));
    check("hang_error", 64'(hang_error), 64'(hang_seen));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      issue_valid = 1'b0;
      flush       = 1'b0;
      #1;
      check("idle_md_start", 64'(md_start), 64'(0));
      check("idle_stall", 64'(stall), 64'(0));
      check("idle_wb_valid", 64'(wb_valid), 64'(0));
      check_hold();
    end
  endtask

  // mode: 0 normal, 1 flush on 3rd WAIT cycle, 2 unit hangs, 3 reset mid-WAIT,
  //       4 flush during START, 5 issue presented together with flush (never accepted).
  // Cycle c=0 is the issue cycle; c=1 is START; the unit raises ready at c=lat+1.
  task automatic run_op(input logic is_div, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [RW-1:0] rd, input int lat, input logic stale, input int mode);
    logic [WIDTH-1:0] res;
    logic             exc;
    logic [63:0]      prod;
    int               stall_end, wb_c, last_c;
    if (is_div) begin
      exc = (b == 0);
      if (b == 0) res = '0;
      else        res = a / b;
    end else begin
      prod = 64'(a) * 64'(b);
      res  = prod[WIDTH-1:0];
      exc  = 1'b0;
    end
    case (mode)
      0:       begin stall_end = lat + 1;     wb_c = lat + 2;     last_c = wb_c; end
      1:       begin stall_end = 4;           wb_c = -1;          last_c = 10;   end
      2:       begin stall_end = TIMEOUT + 2; wb_c = TIMEOUT + 3; last_c = wb_c; end
      3:       begin stall_end = 4;           wb_c = -1;          last_c = 12;   end
      4:       begin stall_end = 1;           wb_c = -1;          last_c = 4;    end
      default: begin stall_end = 0;           wb_c = -1;          last_c = 3;    end
    endcase
    issue_valid  = 1'b1;
    issue_is_div = is_div;
    issue_a      = a;
    issue_b      = b;
    issue_rd     = rd;
    flush        = (mode == 5);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clock);
      issue_valid  = 1'b0;
      issue_is_div = 1'($urandom);
      issue_a      = $urandom;
      issue_b      = $urandom;
      issue_rd     = 5'($urandom);
      if (c <= 2) md_ready = stale;
      else        md_ready = (mode != 2) && (c >= lat + 1);
      if (c > 2 && md_ready) begin
        md_result    = res;
        md_exception = exc;
      end else begin
        md_result    = $urandom;
        md_exception = 1'($urandom);
      end
      flush = (mode == 1 && c == 4) || (mode == 4 && c == 1);
      if (mode == 3 && c == 5) reset_n = 1'b0;
      if (mode == 3 && c == 6) reset_n = 1'b1;
      #1;
      if (mode == 3 && c == 5) begin
        hang_seen = 1'b0;
        last_rd   = '0;
        last_data = '0;
        last_exc  = 1'b0;
      end
      if (c == wb_c) begin
        last_rd   = rd;
        last_data = (mode == 2) ? '0 : res;
        last_exc  = (mode == 2) ? 1'b1 : exc;
        if (mode == 2) hang_seen = 1'b1;
      end
      check("md_start", 64'(md_start), 64'(c == 1 && mode < 4));
      check("stall", 64'(stall), 64'(c <= stall_end));
      check("wb_valid", 64'(wb_valid), 64'(c == wb_c));
      if (c <= stall_end) begin
        check("md_is_div", 64'(md_is_div), 64'(is_div));
        check("md_a", 64'(md_a), 64'(a));
        check("md_b", 64'(md_b), 64'(b));
      end
      if (mode == 3 && c == 5) begin
        check("rst_md_is_div", 64'(md_is_div), 64'(0));
        check("rst_md_a", 64'(md_a), 64'(0));
        check("rst_md_b", 64'(md_b), 64'(0));
      end
      check_hold();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, lat;
    logic [WIDTH-1:0] b;
    reset_n      = 1'b0;
    issue_valid  = 1'b0;
    issue_is_div = 1'b0;
    issue_a      = '0;
    issue_b      = '0;
    issue_rd     = '0;
    flush        = 1'b0;
    md_ready     = 1'b0;
    md_result    = '0;
    md_exception = 1'b0;
    hang_seen    = 1'b0;
    last_rd      = '0;
    last_data    = '0;
    last_exc     = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_md_start", 64'(md_start), 64'(0));
    check("reset_md_is_div", 64'(md_is_div), 64'(0));
    check("reset_md_a", 64'(md_a), 64'(0));
    check("reset_md_b", 64'(md_b), 64'(0));
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_wb_valid", 64'(wb_valid), 64'(0));
    check_hold();
    reset_n = 1'b1;
    idle(2);

    run_op(1'b0, 6, 7, 5, 34, 1'b0, 0);
    idle(1);
    run_op(1'b1, 100, 7, 3, 10, 1'b0, 0);
    run_op(1'b1, 5, 0, 9, 6, 1'b1, 0);
    idle(2);
    run_op(1'b0, 32'h1234, 32'h55, 4, 6, 1'b0, 1);
    run_op(1'b0, 3, 3, 2, 5, 1'b0, 0);
    run_op(1'b0, 11, 13, 7, 8, 1'b1, 0);
    run_op(1'b0, 1, 1, 1, 5, 1'b0, 5);
    run_op(1'b1, 77, 3, 8, 3, 1'b0, 4);
    idle(1);
    run_op(1'b0, 9, 9, 6, 20, 1'b1, 3);
    run_op(1'b0, 2, 2, 1, 5, 1'b0, 2);
    run_op(1'b0, 4, 5, 0, 12, 1'b1, 0);
    idle(2);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        7:       mode = 1;
        8:       mode = 4;
        9:       mode = 5;
        default: mode = 0;
      endcase
      lat = (mode == 1) ? int'($urandom_range(4, 30)) : int'($urandom_range(2, 30));
      b   = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      run_op(1'($urandom), $urandom, b, 5'($urandom), lat, 1'($urandom), mode);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
